iir_biquad_cascade: RTL and testbench

Parametrised multi-channel IIR filter built from a cascade of direct-form-I biquad sections. It time-multiplexes one multiplier across all channels and sections. Coefficients are runtime-loadable through a double-banked write port, with a glitch-free commit at frame boundaries. It sits in the audio path between the core sound mixer and the output DC blocker and generalises the fixed 3-tap stereo IIR.

---
 rtl/iir_cascade_pkg.sv | 16 +
 rtl/iir_mac_unit.sv | 25 ++
 rtl/iir_biquad_cascade.sv | 112 +++++++++++
 tb/tb_iir_biquad_cascade.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/iir_cascade_pkg.sv
// iir_cascade_pkg: shared state/tap types, constants and rounding helper for the biquad cascade
package iir_cascade_pkg;
  typedef enum logic [1:0] {IDLE, MAC, WB, OUT} state_t;
  typedef enum logic [2:0] {B0, B1, B2, A1, A2} tap_t;
  localparam int NUM_TAPS = 5;
  function automatic logic [63:0] unity(input int frac);
    return 64'd1 << frac;
  endfunction
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc, input int frac, input int dw);
    logic signed [63:0] r, hi, lo;
    r = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    return r > hi ? hi : r < lo ? lo : r;
  endfunction
endpackage

// File: rtl/iir_mac_unit.sv
// iir_mac_unit: registered signed multiply-accumulate with rounded, saturated readout
module iir_mac_unit
  import iir_cascade_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 24,
  parameter int ACC_W = 44,
  parameter int COEF_FRAC = 21
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     clr,
  input  logic                     sub,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [COEF_W-1:0] c,
  output logic signed [DATA_W-1:0] res
);
  logic signed [ACC_W-1:0] acc, prod;
  assign prod = ACC_W'(x) * ACC_W'(c);
  always_ff @(posedge clk)
    if (reset) acc <= '0;
    else if (en) acc <= (clr ? '0 : acc) + (sub ? -prod : prod);
  assign res = DATA_W'(round_sat({{(64-ACC_W){acc[ACC_W-1]}}, acc}, COEF_FRAC, DATA_W));
endmodule

// File: rtl/iir_biquad_cascade.sv
// iir_biquad_cascade: multi-channel DF-I biquad cascade sharing one MAC, double-banked coefficients
module iir_biquad_cascade
  import iir_cascade_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int SECTIONS = 2,
  parameter int DATA_W = 16,
  parameter int COEF_W = 24,
  parameter int COEF_FRAC = 21,
  parameter int ACC_W = 44
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   sample_ce,
  input  logic [CHANNELS*DATA_W-1:0]             in_data,
  output logic [CHANNELS*DATA_W-1:0]             out_data,
  output logic                                   out_valid,
  output logic                                   busy,
  output logic                                   overrun,
  input  logic                                   overrun_clr,
  input  logic                                   coef_we,
  input  logic [$clog2(SECTIONS*NUM_TAPS)-1:0]   coef_addr,
  input  logic [COEF_W-1:0]                      coef_data,
  input  logic                                   coef_commit
);
  localparam int NC = SECTIONS * NUM_TAPS;
  localparam int NH = CHANNELS * SECTIONS;
  localparam int AW = $clog2(NC);
  localparam int HW = NH > 1 ? $clog2(NH) : 1;
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam int SW = SECTIONS > 1 ? $clog2(SECTIONS) : 1;
  localparam logic signed [COEF_W-1:0] ONE = COEF_W'(unity(COEF_FRAC));
  state_t state, nxt;
  tap_t tap;
  logic [CW-1:0] ch;
  logic [SW-1:0] sec;
  logic pending, accept, last_sec, last;
  logic [CHANNELS*DATA_W-1:0] in_lat;
  logic signed [COEF_W-1:0] act [NC];
  logic signed [COEF_W-1:0] shd [NC];
  logic signed [DATA_W-1:0] x1 [NH];
  logic signed [DATA_W-1:0] x2 [NH];
  logic signed [DATA_W-1:0] y1 [NH];
  logic signed [DATA_W-1:0] y2 [NH];
  logic signed [DATA_W-1:0] x, op, res;
  logic [HW-1:0] h;
  logic [AW-1:0] ci;
  assign accept = state == IDLE && sample_ce;
  assign busy = state != IDLE;
  assign last_sec = sec == SW'(SECTIONS - 1);
  assign last = last_sec && ch == CW'(CHANNELS - 1);
  assign h = HW'(ch * SECTIONS + sec);
  assign ci = AW'(sec * NUM_TAPS + tap);
  assign x = sec == '0 ? signed'(in_lat[ch*DATA_W +: DATA_W]) : y1[h - 1'b1];
  assign op = tap == B0 ? x : tap == B1 ? x1[h] : tap == B2 ? x2[h] : tap == A1 ? y1[h] : y2[h];
  iir_mac_unit #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W), .COEF_FRAC(COEF_FRAC)) u_mac (
    .clk(clk), .reset(reset), .en(state == MAC), .clr(tap == B0), .sub(tap >= A1),
    .x(op), .c(act[ci]), .res(res)
  );
  always_comb begin
    nxt = state == IDLE ? (sample_ce ? MAC : IDLE) :
          state == MAC ? (tap == A2 ? WB : MAC) :
          state == WB ? (last ? OUT : MAC) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tap <= B0;
      ch <= '0;
      sec <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      in_lat <= '0;
      for (int i = 0; i < NC; i++) begin
        act[i] <= i % NUM_TAPS == 0 ? ONE : '0;
        shd[i] <= i % NUM_TAPS == 0 ? ONE : '0;
      end
      for (int i = 0; i < NH; i++) begin
        x1[i] <= '0;
        x2[i] <= '0;
        y1[i] <= '0;
        y2[i] <= '0;
      end
    end else begin
      state <= nxt;
      out_valid <= state == OUT;
      overrun <= busy && sample_ce ? 1'b1 : overrun_clr ? 1'b0 : overrun;
      pending <= accept ? 1'b0 : coef_commit || pending;
      if (accept) begin
        in_lat <= in_data;
        tap <= B0;
        ch <= '0;
        sec <= '0;
        if (pending || coef_commit) act <= shd;
      end
      if (coef_we && coef_addr < AW'(NC)) shd[coef_addr] <= coef_data;
      if (state == MAC) tap <= tap == A2 ? B0 : tap_t'(tap + 1);
      if (state == WB) begin
        x2[h] <= x1[h];
        x1[h] <= x;
        y2[h] <= y1[h];
        y1[h] <= res;
        sec <= last_sec ? '0 : sec + 1'b1;
        ch <= last_sec ? ch + 1'b1 : ch;
      end
      if (state == OUT)
        for (int c = 0; c < CHANNELS; c++) out_data[c*DATA_W +: DATA_W] <= y1[c*SECTIONS + SECTIONS - 1];
    end
  end
endmodule

// File: tb/tb_iir_biquad_cascade.sv
// tb_iir_biquad_cascade: directed checks of a 2x2 and a 1x1 cascade against hand-computed results
module tb_iir_biquad_cascade;
  logic clk = 0, reset = 1, oclr = 0;
  logic [23:0] cdata = '0;
  logic ce2 = 0, we2 = 0, cm2 = 0, ov2, bz2, or2;
  logic [3:0] addr2 = '0;
  logic [31:0] in2 = '0, out2;
  logic ce1 = 0, we1 = 0, cm1 = 0, v1, bz1, or1;
  logic [2:0] addr1 = '0;
  logic [15:0] in1 = '0, out1;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  iir_biquad_cascade #(.CHANNELS(2), .SECTIONS(2)) u2 (
    .clk(clk), .reset(reset), .sample_ce(ce2), .in_data(in2), .out_data(out2), .out_valid(ov2),
    .busy(bz2), .overrun(or2), .overrun_clr(oclr), .coef_we(we2), .coef_addr(addr2),
    .coef_data(cdata), .coef_commit(cm2)
  );
  iir_biquad_cascade #(.CHANNELS(1), .SECTIONS(1)) u1 (
    .clk(clk), .reset(reset), .sample_ce(ce1), .in_data(in1), .out_data(out1), .out_valid(v1),
    .busy(bz1), .overrun(or1), .overrun_clr(oclr), .coef_we(we1), .coef_addr(addr1),
    .coef_data(cdata), .coef_commit(cm1)
  );
  task automatic wc2(input logic [3:0] a, input logic [23:0] d);
    @(negedge clk); we2 = 1; addr2 = a; cdata = d;
    @(negedge clk); we2 = 0;
  endtask
  task automatic wc1(input logic [2:0] a, input logic [23:0] d);
    @(negedge clk); we1 = 1; addr1 = a; cdata = d;
    @(negedge clk); we1 = 0;
  endtask
  task automatic run2(input logic [31:0] d, input logic cm, output logic [31:0] q, output int lat, output int bbad);
    @(negedge clk); ce2 = 1; cm2 = cm; in2 = d;
    @(negedge clk); ce2 = 0; cm2 = 0; in2 = '0;
    lat = 0; bbad = 0;
    while (!ov2 && lat < 100) begin
      if (!bz2) bbad++;
      lat++;
      @(negedge clk);
    end
    if (bz2) bbad++;
    q = out2;
  endtask
  task automatic run1(input logic [15:0] d, output logic [15:0] q, output int lat);
    @(negedge clk); ce1 = 1; in1 = d;
    @(negedge clk); ce1 = 0; in1 = '0;
    lat = 0;
    while (!v1 && lat < 100) begin
      lat++;
      @(negedge clk);
    end
    q = out1;
  endtask
  task automatic test_reset;
    reset = 1;
    repeat (2) @(negedge clk);
    tests++; if (out2 !== 32'h0) begin fails++; $display("FAIL reset_out2: got %h want 0", out2); end
    tests++; if (ov2 !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", ov2); end
    tests++; if (bz2 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bz2); end
    tests++; if (or2 !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b want 0", or2); end
    tests++; if (out1 !== 16'h0) begin fails++; $display("FAIL reset_out1: got %h want 0", out1); end
    reset = 0;
  endtask
  task automatic test_passthrough;
    logic [31:0] q;
    int lat, bbad;
    run2(32'hEDCC_1234, 0, q, lat, bbad);
    tests++; if (q !== 32'hEDCC_1234) begin fails++; $display("FAIL pass_data: got %h want edcc1234", q); end
    tests++; if (lat !== 25) begin fails++; $display("FAIL pass_latency: got %0d want 25", lat); end
    tests++; if (bbad !== 0) begin fails++; $display("FAIL pass_busy: got %0d bad cycles want 0", bbad); end
    repeat (5) @(negedge clk);
    tests++; if (out2 !== 32'hEDCC_1234) begin fails++; $display("FAIL pass_hold: got %h want edcc1234", out2); end
    tests++; if (ov2 !== 1'b0) begin fails++; $display("FAIL pass_pulse: got %b want 0", ov2); end
  endtask
  task automatic test_impulse;
    logic [15:0] q;
    logic [15:0] exp_q [4] = '{16'h2000, 16'h1000, 16'h0800, 16'h0400};
    int lat;
    wc1(3'd0, 24'h100000);
    wc1(3'd3, 24'hF00000);
    @(negedge clk); cm1 = 1;
    @(negedge clk); cm1 = 0;
    for (int i = 0; i < 4; i++) begin
      run1(i == 0 ? 16'h4000 : 16'h0000, q, lat);
      tests++; if (q !== exp_q[i]) begin fails++; $display("FAIL impulse_%0d: got %h want %h", i, q, exp_q[i]); end
      tests++; if (lat !== 7) begin fails++; $display("FAIL impulse_lat_%0d: got %0d want 7", i, lat); end
    end
  endtask
  task automatic test_commit;
    logic [31:0] q;
    int lat, bbad, n;
    wc2(4'd0, 24'h100000);
    run2(32'hEDCC_1234, 0, q, lat, bbad);
    tests++; if (q !== 32'hEDCC_1234) begin fails++; $display("FAIL commit_none: got %h want edcc1234", q); end
    @(negedge clk); cm2 = 1;
    @(negedge clk); cm2 = 0;
    run2(32'hEDCC_1234, 0, q, lat, bbad);
    tests++; if (q !== 32'hF6E6_091A) begin fails++; $display("FAIL commit_half: got %h want f6e6091a", q); end
    @(negedge clk); ce2 = 1; in2 = 32'hEDCC_1234;
    @(negedge clk); ce2 = 0; in2 = '0; we2 = 1; addr2 = 4'd0; cdata = 24'h200000; cm2 = 1;
    @(negedge clk); we2 = 0; cm2 = 0;
    n = 0;
    while (!ov2 && n < 100) begin n++; @(negedge clk); end
    tests++; if (out2 !== 32'hF6E6_091A) begin fails++; $display("FAIL commit_midframe: got %h want f6e6091a", out2); end
    run2(32'hEDCC_1234, 0, q, lat, bbad);
    tests++; if (q !== 32'hEDCC_1234) begin fails++; $display("FAIL commit_after: got %h want edcc1234", q); end
  endtask
  task automatic test_saturation;
    logic [31:0] q;
    int lat, bbad;
    wc2(4'd0, 24'h7FFFFF);
    run2(32'hC000_4000, 1, q, lat, bbad);
    tests++; if (q !== 32'h8000_7FFF) begin fails++; $display("FAIL saturate: got %h want 80007fff", q); end
    wc2(4'd0, 24'h200000);
    @(negedge clk); cm2 = 1;
    @(negedge clk); cm2 = 0;
  endtask
  task automatic test_overrun;
    int nv, at;
    tests++; if (or2 !== 1'b0) begin fails++; $display("FAIL overrun_pre: got %b want 0", or2); end
    @(negedge clk); ce2 = 1; in2 = 32'h0102_0304;
    @(negedge clk); ce2 = 0; in2 = '0;
    nv = 0; at = -1;
    for (int c = 0; c < 40; c++) begin
      if (ov2) begin nv++; at = c; end
      ce2 = c == 10;
      in2 = c == 10 ? 32'h7777_7777 : 32'h0;
      @(negedge clk);
    end
    ce2 = 0;
    tests++; if (nv !== 1 || at !== 25) begin fails++; $display("FAIL overrun_pulses: got %0d at %0d want 1 at 25", nv, at); end
    tests++; if (out2 !== 32'h0102_0304) begin fails++; $display("FAIL overrun_data: got %h want 01020304", out2); end
    tests++; if (or2 !== 1'b1) begin fails++; $display("FAIL overrun_set: got %b want 1", or2); end
    oclr = 1;
    @(negedge clk); oclr = 0;
    tests++; if (or2 !== 1'b0) begin fails++; $display("FAIL overrun_clr: got %b want 0", or2); end
  endtask
  task automatic test_reset_mid;
    logic [31:0] q;
    int lat, bbad, nv;
    wc2(4'd0, 24'h100000);
    @(negedge clk); cm2 = 1;
    @(negedge clk); cm2 = 0;
    @(negedge clk); ce2 = 1; in2 = 32'h0555_0AAA;
    @(negedge clk); ce2 = 0; in2 = '0;
    repeat (12) @(negedge clk);
    reset = 1;
    @(negedge clk); reset = 0;
    nv = 0;
    for (int c = 0; c < 40; c++) begin
      if (ov2) nv++;
      @(negedge clk);
    end
    tests++; if (nv !== 0) begin fails++; $display("FAIL rst_mid_valid: got %0d pulses want 0", nv); end
    tests++; if (out2 !== 32'h0) begin fails++; $display("FAIL rst_mid_data: got %h want 0", out2); end
    tests++; if (bz2 !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %b want 0", bz2); end
    run2(32'h8001_7FFF, 0, q, lat, bbad);
    tests++; if (q !== 32'h8001_7FFF) begin fails++; $display("FAIL rst_mid_pass: got %h want 80017fff", q); end
    tests++; if (lat !== 25) begin fails++; $display("FAIL rst_mid_lat: got %0d want 25", lat); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_passthrough;
    test_impulse;
    test_commit;
    test_saturation;
    test_overrun;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
